// File: rtl/fifo_pack_if.sv
// Byte-in / word-out bus for fifo_pack. The flush strobe exists only when FIFO_PACK_FLUSH_EN is defined.
interface fifo_pack_if;
   logic        en_w;
   logic [7:0]  data_in;
   logic        en_r;
   logic [31:0] data_out;
   logic        full_flag;
   logic        empty_flag;
   logic [1:0]  lane;
`ifdef FIFO_PACK_FLUSH_EN
   logic        flush;

   modport master (output en_w, data_in, en_r, flush,
                   input  data_out, full_flag, empty_flag, lane);
   modport slave  (input  en_w, data_in, en_r, flush,
                   output data_out, full_flag, empty_flag, lane);
`else
   modport master (output en_w, data_in, en_r,
                   input  data_out, full_flag, empty_flag, lane);
   modport slave  (input  en_w, data_in, en_r,
                   output data_out, full_flag, empty_flag, lane);
`endif
endinterface

// File: rtl/fifo_pack.sv
// Byte-to-word packing FIFO: groups of 4 bytes become one 32-bit word in a DEPTH-entry ring.
// Optional FIFO_PACK_FLUSH_EN adds a flush strobe that pushes a partial group zero-padded.
module fifo_pack #(
   parameter int unsigned DEPTH      = 8,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   fifo_pack_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   mem [DEPTH];

   logic [31:0]   asm_q,    asm_d;
   logic [1:0]    lane_q,   lane_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic [31:0]   dout_q,   dout_d;
   logic          full_q,   full_d;
   logic          empty_q,  empty_d;

   logic          wr_ok, rd_ok, flush_ok, push;
   logic [4:0]    pos;
   logic [31:0]   word_c;

   // Next-state: both strobes are judged against the registered flags.
   always_comb begin
      wr_ok    = bus.en_w && !full_q;
      rd_ok    = bus.en_r && !empty_q;
      pos      = BIG_ENDIAN ? {~lane_q, 3'b000} : {lane_q, 3'b000};
      word_c   = asm_q;
      if (wr_ok) word_c[pos +: 8] = bus.data_in;
`ifdef FIFO_PACK_FLUSH_EN
      flush_ok = bus.flush && !full_q && (lane_q != 2'd0);
`else
      flush_ok = 1'b0;
`endif
      push     = (wr_ok && (lane_q == 2'd3)) || flush_ok;

      // Clearing on push keeps unfilled slots zero for a later flush.
      asm_d    = push ? '0 : word_c;
      lane_d   = push ? 2'd0 : (wr_ok ? lane_q + 2'd1 : lane_q);
      wr_ptr_d = push  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      dout_d   = rd_ok ? mem[rd_ptr_q] : dout_q;

      case ({push, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Word storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= word_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         asm_q    <= '0;
         lane_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         asm_q    <= asm_d;
         lane_q   <= lane_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.full_flag  = full_q;
   assign bus.empty_flag = empty_q;
   assign bus.lane       = lane_q;

endmodule
